// File: rtl/ifm_chunk_packer.sv
// Packs dense IFM groups into one compressed chunk: non-zero elements go to consecutive
// data addresses, one sparsemap word per group. Optional IFM_PACKER_PIPE_EN removes the IDLE bubble.
module ifm_chunk_packer #(
    parameter int DATA_W     = 8,
    parameter int GROUP_SIZE = 32,
    parameter int CHUNK_SIZE = 128
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 in_valid_i,
    output logic                                 in_ready_o,
    input  logic [GROUP_SIZE*DATA_W-1:0]         in_data_i,
    input  logic                                 in_last_i,
    output logic                                 dat_wr_en_o,
    output logic [$clog2(CHUNK_SIZE):0]          dat_wr_addr_o,
    output logic [DATA_W-1:0]                    dat_wr_data_o,
    output logic                                 smap_wr_en_o,
    output logic [((CHUNK_SIZE/GROUP_SIZE) > 1 ? $clog2(CHUNK_SIZE/GROUP_SIZE) : 1)-1:0] smap_wr_addr_o,
    output logic [GROUP_SIZE-1:0]                smap_wr_data_o,
    output logic                                 chunk_done_o,
    output logic [$clog2(CHUNK_SIZE):0]          chunk_nz_cnt_o
);

    localparam int GROUPS_PER_CHUNK = CHUNK_SIZE / GROUP_SIZE;
    localparam int PTR_W  = $clog2(CHUNK_SIZE) + 1;
    localparam int GIDX_W = (GROUPS_PER_CHUNK > 1) ? $clog2(GROUPS_PER_CHUNK) : 1;
    localparam int K_W    = (GROUP_SIZE > 1) ? $clog2(GROUP_SIZE) : 1;
    localparam logic [GIDX_W-1:0] GIDX_LAST = GIDX_W'(GROUPS_PER_CHUNK - 1);
`ifdef IFM_PACKER_PIPE_EN
    localparam logic PIPE_EN = 1'b1;
`else
    localparam logic PIPE_EN = 1'b0;
`endif

    typedef enum logic [0:0] {IDLE = 1'b0, SCAN = 1'b1} state_t;

    function automatic logic [GROUP_SIZE-1:0] sparsemap_f(input logic [GROUP_SIZE*DATA_W-1:0] d);
        logic [GROUP_SIZE-1:0] m;
        for (int i = 0; i < GROUP_SIZE; i++) begin
            m[i] = |d[i*DATA_W +: DATA_W];
        end
        return m;
    endfunction

    function automatic logic [K_W-1:0] lowest_f(input logic [GROUP_SIZE-1:0] m);
        logic [K_W-1:0] k;
        k = '0;
        for (int i = GROUP_SIZE - 1; i >= 0; i--) begin
            k = m[i] ? K_W'(i) : k;
        end
        return k;
    endfunction

    // True when the mask has at most one bit set, i.e. this is the group's last scan cycle
    function automatic logic at_most_one_f(input logic [GROUP_SIZE-1:0] m);
        return (m & (m - GROUP_SIZE'(1))) == '0;
    endfunction

    function automatic logic [DATA_W-1:0] elem_f(input logic [GROUP_SIZE*DATA_W-1:0] d,
                                                 input logic [K_W-1:0] k);
        return d[k*DATA_W +: DATA_W];
    endfunction

    state_t                       state_r, state_s;
    logic [GROUP_SIZE*DATA_W-1:0] data_r, data_s;
    logic [GROUP_SIZE-1:0]        smap_r, smap_s;
    logic [GROUP_SIZE-1:0]        pending_r, pending_s;
    logic                         first_r, first_s;
    logic                         last_r, last_s;
    logic [PTR_W-1:0]             wptr_r, wptr_s;
    logic [GIDX_W-1:0]            gidx_r, gidx_s;

    logic                         accept_s;
    logic                         scan_end_s;
    logic                         wr_s;
    logic                         close_s;

    logic                         in_ready_r, out_ready_s;
    logic                         dat_wr_en_r, out_dat_en_s;
    logic [PTR_W-1:0]             dat_wr_addr_r, out_dat_addr_s;
    logic [DATA_W-1:0]            dat_wr_data_r, out_dat_data_s;
    logic                         smap_wr_en_r, out_smap_en_s;
    logic [GIDX_W-1:0]            smap_wr_addr_r, out_smap_addr_s;
    logic [GROUP_SIZE-1:0]        smap_wr_data_r, out_smap_data_s;
    logic                         chunk_done_r, out_done_s;
    logic [PTR_W-1:0]             chunk_nz_cnt_r, out_nz_s;
    logic                         out_wr_s;
    logic                         out_end_s;

    // Next-state: group acceptance, pending-bit consumption, pointer and group-index update
    always_comb begin
        state_s    = state_r;
        data_s     = data_r;
        smap_s     = smap_r;
        pending_s  = pending_r;
        first_s    = first_r;
        last_s     = last_r;
        wptr_s     = wptr_r;
        gidx_s     = gidx_r;
        accept_s   = in_valid_i & in_ready_r;
        scan_end_s = at_most_one_f(pending_r);
        wr_s       = |pending_r;
        close_s    = (gidx_r == GIDX_LAST) | last_r;
        case (state_r)
            IDLE: begin
                state_s = IDLE;
            end
            SCAN: begin
                pending_s = pending_r & (pending_r - GROUP_SIZE'(1));
                first_s   = 1'b0;
                wptr_s    = wptr_r + PTR_W'(wr_s);
                if (scan_end_s) begin
                    state_s = IDLE;
                    if (close_s) begin
                        wptr_s = '0;
                        gidx_s = '0;
                    end else begin
                        gidx_s = gidx_r + GIDX_W'(1);
                    end
                end else begin
                    state_s = SCAN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        // A pipelined accept in the last scan cycle overrides the return to IDLE
        if (accept_s) begin
            state_s   = SCAN;
            data_s    = in_data_i;
            smap_s    = sparsemap_f(in_data_i);
            pending_s = sparsemap_f(in_data_i);
            first_s   = 1'b1;
            last_s    = in_last_i;
        end else begin
            last_s = last_s;
        end
    end

    // Output decode from next-state so every port comes straight from a flop
    always_comb begin
        out_ready_s     = 1'b1;
        out_dat_en_s    = 1'b0;
        out_dat_addr_s  = '0;
        out_dat_data_s  = '0;
        out_smap_en_s   = 1'b0;
        out_smap_addr_s = '0;
        out_smap_data_s = '0;
        out_done_s      = 1'b0;
        out_nz_s        = '0;
        out_wr_s        = |pending_s;
        out_end_s       = at_most_one_f(pending_s);
        if (state_s == SCAN) begin
            out_ready_s  = PIPE_EN & out_end_s;
            out_dat_en_s = out_wr_s;
            if (out_wr_s) begin
                out_dat_addr_s = wptr_s;
                out_dat_data_s = elem_f(data_s, lowest_f(pending_s));
            end else begin
                out_dat_addr_s = '0;
            end
            if (first_s) begin
                out_smap_en_s   = 1'b1;
                out_smap_addr_s = gidx_s;
                out_smap_data_s = smap_s;
            end else begin
                out_smap_en_s = 1'b0;
            end
            if (out_end_s && ((gidx_s == GIDX_LAST) || last_s)) begin
                out_done_s = 1'b1;
                out_nz_s   = wptr_s + PTR_W'(out_wr_s);
            end else begin
                out_done_s = 1'b0;
            end
        end else begin
            out_ready_s = 1'b1;
        end
    end

    // Packer state registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r   <= IDLE;
            data_r    <= '0;
            smap_r    <= '0;
            pending_r <= '0;
            first_r   <= 1'b0;
            last_r    <= 1'b0;
            wptr_r    <= '0;
            gidx_r    <= '0;
        end else begin
            state_r   <= state_s;
            data_r    <= data_s;
            smap_r    <= smap_s;
            pending_r <= pending_s;
            first_r   <= first_s;
            last_r    <= last_s;
            wptr_r    <= wptr_s;
            gidx_r    <= gidx_s;
        end
    end

    // Registered output ports
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            in_ready_r     <= 1'b1;
            dat_wr_en_r    <= 1'b0;
            dat_wr_addr_r  <= '0;
            dat_wr_data_r  <= '0;
            smap_wr_en_r   <= 1'b0;
            smap_wr_addr_r <= '0;
            smap_wr_data_r <= '0;
            chunk_done_r   <= 1'b0;
            chunk_nz_cnt_r <= '0;
        end else begin
            in_ready_r     <= out_ready_s;
            dat_wr_en_r    <= out_dat_en_s;
            dat_wr_addr_r  <= out_dat_addr_s;
            dat_wr_data_r  <= out_dat_data_s;
            smap_wr_en_r   <= out_smap_en_s;
            smap_wr_addr_r <= out_smap_addr_s;
            smap_wr_data_r <= out_smap_data_s;
            chunk_done_r   <= out_done_s;
            chunk_nz_cnt_r <= out_nz_s;
        end
    end

    assign in_ready_o     = in_ready_r;
    assign dat_wr_en_o    = dat_wr_en_r;
    assign dat_wr_addr_o  = dat_wr_addr_r;
    assign dat_wr_data_o  = dat_wr_data_r;
    assign smap_wr_en_o   = smap_wr_en_r;
    assign smap_wr_addr_o = smap_wr_addr_r;
    assign smap_wr_data_o = smap_wr_data_r;
    assign chunk_done_o   = chunk_done_r;
    assign chunk_nz_cnt_o = chunk_nz_cnt_r;

endmodule
